// File: rtl/sha_pad_pkg.sv
// sha_pad_pkg: shared SHA-256 padding constants and byte-order helpers.
package sha_pad_pkg;
  localparam int BLOCK_W = 512;
  localparam int LEN_W = 64;
  localparam int MAX_BLK = 4;
  localparam int VEC_W = BLOCK_W * MAX_BLK;

  function automatic int nblk(input int l);
    return (l + LEN_W) / BLOCK_W + 1;
  endfunction

  // Places byte k of value (LSByte first) at the top of the vector, k-th byte down.
  function automatic logic [VEC_W-1:0] bswap_le(input logic [VEC_W-1:0] value, input int bytes);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int k = 0; k < VEC_W / 8; k++)
      if (k < bytes) r[VEC_W-1-8*k -: 8] = value[8*k +: 8];
    return r;
  endfunction
endpackage

// File: rtl/sha_pad_builder.sv
// sha_pad_builder: combinational proof/nonce/block-index to padded 512-bit block.
module sha_pad_builder
  import sha_pad_pkg::*;
#(
  parameter int PROOF_W = 32,
  parameter int NONCE_W = 64
) (
  input  logic [PROOF_W-1:0] proof,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [1:0]         idx,
  output logic [BLOCK_W-1:0] block
);
  localparam int L = PROOF_W + NONCE_W;
  localparam int NB = nblk(L);
  logic [VEC_W-1:0] vec;
  // Padded message is built MSB-aligned in a 4-block vector; unused trailing blocks are never selected.
  always_comb begin
    vec = bswap_le(VEC_W'({nonce, proof}), L / 8);
    vec[VEC_W-1-L -: 8] = 8'h80;
    vec[VEC_W-NB*BLOCK_W +: LEN_W] = LEN_W'(L);
  end
  assign block = vec[VEC_W-1-BLOCK_W*32'(idx) -: BLOCK_W];
endmodule

// File: rtl/nonce_block_padder.sv
// nonce_block_padder: streams padded SHA-256 blocks for a sweep of consecutive nonces.
module nonce_block_padder
  import sha_pad_pkg::*;
#(
  parameter int PROOF_W = 32,
  parameter int NONCE_W = 64,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PROOF_W-1:0] in_proof,
  input  logic [NONCE_W-1:0] in_nonce,
  input  logic [COUNT_W-1:0] in_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [511:0]       out_block,
  output logic [NONCE_W-1:0] out_nonce,
  output logic               out_first,
  output logic               out_last,
  output logic               out_done
);
  localparam int L = PROOF_W + NONCE_W;
  localparam int NB = nblk(L);
  localparam logic [1:0] LAST_IDX = 2'(NB - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  if (L > 1976 || PROOF_W % 8 != 0 || NONCE_W % 8 != 0 || PROOF_W < 8 || NONCE_W < 8) begin : g_bad
    $error("nonce_block_padder: unsupported PROOF_W/NONCE_W");
  end

  logic [0:0] state, n_state;
  logic [1:0] idx, n_idx;
  logic [PROOF_W-1:0] proof, n_proof;
  logic [NONCE_W-1:0] nonce, n_nonce;
  logic [COUNT_W-1:0] rem, n_rem;
  logic [BLOCK_W-1:0] blk;
  logic hs;

  assign in_ready = state == IDLE && rst_n;
  assign hs = out_valid && out_ready;

  always_comb begin
    n_state = state;
    n_idx = idx;
    n_proof = proof;
    n_nonce = nonce;
    n_rem = rem;
    if (state == IDLE && in_valid) begin
      n_state = EMIT;
      n_idx = 2'd0;
      n_proof = in_proof;
      n_nonce = in_nonce;
      n_rem = in_count == '0 ? COUNT_W'(1) : in_count;
    end else if (state == EMIT && hs) begin
      if (idx != LAST_IDX) n_idx = idx + 2'd1;
      else if (rem > COUNT_W'(1)) begin
        n_idx = 2'd0;
        n_nonce = nonce + NONCE_W'(1);
        n_rem = rem - COUNT_W'(1);
      end else begin
        n_state = IDLE;
        n_rem = '0;
      end
    end
  end

  // Build from next-state values so the output register holds the block of the state it enters.
  sha_pad_builder #(.PROOF_W(PROOF_W), .NONCE_W(NONCE_W)) u_builder (
    .proof(n_proof),
    .nonce(n_nonce),
    .idx  (n_idx),
    .block(blk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      proof <= '0;
      nonce <= '0;
      rem <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      out_done <= 1'b0;
      out_block <= '0;
      out_nonce <= '0;
    end else begin
      state <= n_state;
      idx <= n_idx;
      proof <= n_proof;
      nonce <= n_nonce;
      rem <= n_rem;
      out_valid <= n_state == EMIT;
      out_first <= n_state == EMIT && n_idx == 2'd0;
      out_last <= n_state == EMIT && n_idx == LAST_IDX;
      out_done <= n_state == EMIT && n_idx == LAST_IDX && n_rem == COUNT_W'(1);
      if (n_state == EMIT) begin
        out_block <= blk;
        out_nonce <= n_nonce;
      end
    end
  end
endmodule
